// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester that turns cmd_* requests into SETUP/ACCESS transfers.
// Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles (rsp_err=1).
module apb_master #(
  parameter int ADDR_W         = 33,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              pSelect,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddress,
  output logic [7:0]        pWData,
  input  logic [7:0]        pRData,
  input  logic              pReady,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       accept;
  logic       done;
  logic       abort;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the requester holds cmd_* stable while cmd_valid is high and not yet accepted.
  assign done      = (state == ACCESS) && pReady;
  assign cmd_ready = (state == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;
  assign fsm_state = state;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state     <= IDLE;
      pSelect   <= 1'b0;
      pEnable   <= 1'b0;
      pWrite    <= 1'b0;
      pAddress  <= '0;
      pWData    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        pWrite   <= cmd_write;
        pAddress <= cmd_addr;
        pWData   <= cmd_wdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            pSelect <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          pEnable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid <= 1'b1;
            if (!pWrite) rsp_rdata <= pRData;
            pEnable <= 1'b0;
            // A command taken on the completing edge keeps pSelect high and re-enters SETUP.
            if (accept) begin
              state <= SETUP;
            end else begin
              pSelect <= 1'b0;
              state   <= IDLE;
            end
          end else if (abort) begin
            rsp_valid <= 1'b1;
            pSelect   <= 1'b0;
            pEnable   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          pSelect <= 1'b0;
          pEnable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;

  // The abort fires on the TIMEOUT_CYCLES-th ACCESS cycle that still sees pReady low.
  assign abort   = (state == ACCESS) && !pReady && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = rsp_err_q;

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= abort;
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pReady) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;

  // TIMEOUT_CYCLES only matters when the abort path is built in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a transaction-level model checked every cycle.
// Timeout scenarios are compiled in when APB_TIMEOUT_EN is defined.
module tb_apb_master;

  localparam int AW = 33;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          pClk = 1'b0;
  logic          pReset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          rsp_err;
  logic          pSelect;
  logic          pEnable;
  logic          pWrite;
  logic [AW-1:0] pAddress;
  logic [7:0]    pWData;
  logic [7:0]    pRData = 8'h00;
  logic          pReady = 1'b0;
  logic [1:0]    fsm_state;

  apb_master #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .pClk(pClk), .pReset(pReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pSelect(pSelect), .pEnable(pEnable), .pWrite(pWrite),
    .pAddress(pAddress), .pWData(pWData), .pRData(pRData), .pReady(pReady),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 pClk = ~pClk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;

  always @(posedge pClk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s @cyc %0d: bound expired", name, cyc);
  endtask

  // ---------------- APB completer: slv_waits low cycles, then pReady ----------------
  int         slv_waits = 0;
  logic [7:0] slv_rdata = 8'h00;
  bit         in_acc = 1'b0;
  int         wcnt = 0;

  always @(posedge pClk) begin
    #1;
    if (pSelect && pEnable) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        wcnt = 0;
      end else begin
        wcnt++;
      end
      pReady = (wcnt >= slv_waits);
      pRData = pReady ? slv_rdata : 8'($urandom_range(0, 255));
    end else begin
      // Noise outside ACCESS must have no effect on the master.
      in_acc = 1'b0;
      pReady = 1'($urandom_range(0, 1));
      pRData = 8'($urandom_range(0, 255));
    end
  end

  // ---------------- transaction model ----------------
  bit            m_active = 1'b0;
  int            m_phase = 0;      // 0 = setup cycle, n>=1 = n-th access cycle
  logic          m_w = 1'b0;
  logic [AW-1:0] m_a = '0;
  logic [7:0]    m_d = 8'h00;
  bit            m_rsp_valid = 1'b0;
  bit            m_rsp_err = 1'b0;
  logic [7:0]    m_rdata = 8'h00;

  always @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      m_active = 1'b0; m_phase = 0; m_rsp_valid = 1'b0; m_rsp_err = 1'b0; m_rdata = 8'h00;
    end else begin
      m_rsp_valid = 1'b0;
      m_rsp_err   = 1'b0;
      if (!m_active) begin
        if (cmd_valid) begin
          m_active = 1'b1; m_phase = 0; m_w = cmd_write; m_a = cmd_addr; m_d = cmd_wdata;
        end
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (pReady) begin
        m_rsp_valid = 1'b1;
        if (!m_w) m_rdata = pRData;
        if (cmd_valid) begin
          m_phase = 0; m_w = cmd_write; m_a = cmd_addr; m_d = cmd_wdata;
        end else begin
          m_active = 1'b0;
        end
      end else if (TO_EN && m_phase == TO) begin
        m_rsp_valid = 1'b1; m_rsp_err = 1'b1; m_active = 1'b0;
      end else begin
        m_phase++;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge pClk) begin
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_active || (m_phase >= 1 && pReady)));
    chk("pSelect", 64'(pSelect), 64'(m_active));
    chk("pEnable", 64'(pEnable), 64'(m_active && m_phase >= 1));
    if (m_active) begin
      chk("pWrite", 64'(pWrite), 64'(m_w));
      chk("pAddress", 64'(pAddress), 64'(m_a));
      chk("pWData", 64'(pWData), 64'(m_d));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
    if (m_rsp_valid) chk("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [7:0] d);
    int n;
    @(posedge pClk); #1;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge pClk);
      if (cmd_ready) break;
      n++;
      if (n > 100) begin
        fail_now("accept_wait");
        break;
      end
    end
    accept_cyc = cyc;
    @(posedge pClk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int acc);
    acc = 0;
    lat = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge pClk);
      if (rsp_valid) begin
        lat = cyc - accept_cyc;
        return;
      end
      if (pSelect && pEnable) acc++;
    end
    fail_now("rsp_wait");
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
    int            waits;
    logic [7:0]    r;
    logic [7:0]    exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat, acc, n_setup, n_low, rv;
    tbl[0] = '{1'b1, 33'h1_0000_0ABC, 8'h11, 1, 8'h99, 8'h3C, 4};
    tbl[1] = '{1'b0, 33'h0_0000_0020, 8'h00, 0, 8'h77, 8'h77, 3};
    tbl[2] = '{1'b1, 33'h1_FFFF_FFFF, 8'hFF, 2, 8'h55, 8'h77, 5};
    tbl[3] = '{1'b0, 33'h0_8000_0001, 8'h00, 3, 8'h0F, 8'h0F, 6};

    pReset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = 8'h00;
    repeat (3) @(negedge pClk);
    chk("rst_pSelect", 64'(pSelect), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    pReset = 1'b1;

    // Write 0x5A to 0x4, zero wait states.
    slv_waits = 0;
    issue(1'b1, 33'h4, 8'h5A);
    @(negedge pClk);
    chk("w_setup", 64'({pSelect, pEnable}), 64'h2);
    @(negedge pClk);
    chk("w_access", 64'({pSelect, pEnable}), 64'h3);
    chk("w_pWData", 64'(pWData), 64'h5A);
    chk("w_pAddress", 64'(pAddress), 64'h4);
    wait_rsp(lat, acc);
    chk("w_latency", 64'(lat), 64'd3);
    chk("w_rsp_err", 64'(rsp_err), 64'd0);

    // Read 0x8 with two wait states.
    slv_waits = 2; slv_rdata = 8'hC3;
    issue(1'b0, 33'h8, 8'h00);
    wait_rsp(lat, acc);
    chk("r_access_cycles", 64'(acc), 64'd3);
    chk("r_latency", 64'(lat), 64'd5);
    chk("r_rdata", 64'(rsp_rdata), 64'hC3);

    // Back-to-back write then read with cmd_valid held.
    slv_waits = 0; slv_rdata = 8'h3C;
    @(posedge pClk); #1;
    cmd_write = 1'b1; cmd_addr = 33'h40; cmd_wdata = 8'hA5; cmd_valid = 1'b1;
    rv = 0;
    forever begin
      @(negedge pClk);
      if (cmd_ready) break;
      rv++;
      if (rv > 100) begin
        fail_now("b2b_accept_wait");
        break;
      end
    end
    @(posedge pClk); #1;
    cmd_write = 1'b0; cmd_addr = 33'h44;
    n_setup = 0; n_low = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pClk);
      if (!pSelect) n_low++;
      if (pSelect && !pEnable) n_setup++;
      if (i == 1) begin
        @(posedge pClk); #1;
        cmd_valid = 1'b0;
      end
    end
    chk("b2b_select_drops", 64'(n_low), 64'd0);
    chk("b2b_setup_cycles", 64'(n_setup), 64'd2);
    wait_rsp(lat, acc);
    chk("b2b_rdata", 64'(rsp_rdata), 64'h3C);

    for (int i = 0; i < 4; i++) begin
      slv_waits = tbl[i].waits; slv_rdata = tbl[i].r;
      issue(tbl[i].w, tbl[i].a, tbl[i].d);
      wait_rsp(lat, acc);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_access", i), 64'(acc), 64'(tbl[i].waits + 1));
      chk($sformatf("vec%0d_rdata", i), 64'(rsp_rdata), 64'(tbl[i].exp_rdata));
    end

    // Reset asserted in the middle of a stalled ACCESS.
    slv_waits = 1000;
    issue(1'b1, 33'h1_2345_6789, 8'hE1);
    @(negedge pClk);
    @(negedge pClk);
    chk("mid_access", 64'(pEnable), 64'd1);
    #2;
    pReset = 1'b0;
    #1;
    chk("arst_outputs", 64'({pSelect, pEnable, pWrite, rsp_valid, rsp_err}), 64'd0);
    chk("arst_pAddress", 64'(pAddress), 64'd0);
    chk("arst_pWData", 64'(pWData), 64'd0);
    chk("arst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge pClk);
    @(negedge pClk);
    pReset = 1'b1; slv_waits = 0;
    rv = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pClk);
      if (i == 0) chk("arst_release_ready", 64'(cmd_ready), 64'd1);
      if (rsp_valid) rv++;
    end
    chk("arst_no_rsp", 64'(rv), 64'd0);

`ifdef APB_TIMEOUT_EN
    slv_waits = 0; slv_rdata = 8'h77;
    issue(1'b0, 33'h20, 8'h00);
    wait_rsp(lat, acc);
    chk("to_pre_rdata", 64'(rsp_rdata), 64'h77);

    // pReady stuck low: abort after TO access cycles.
    slv_waits = 1000;
    issue(1'b0, 33'h10, 8'h00);
    wait_rsp(lat, acc);
    chk("to_access_cycles", 64'(acc), 64'd4);
    chk("to_latency", 64'(lat), 64'd6);
    chk("to_rsp_err", 64'(rsp_err), 64'd1);
    chk("to_rdata_kept", 64'(rsp_rdata), 64'h77);
    @(negedge pClk);
    chk("to_idle_select", 64'(pSelect), 64'd0);
    chk("to_idle_ready", 64'(cmd_ready), 64'd1);

    // pReady arrives on the would-be timeout cycle: normal completion.
    slv_waits = 3; slv_rdata = 8'hA7;
    issue(1'b0, 33'h14, 8'h00);
    wait_rsp(lat, acc);
    chk("to_edge_access", 64'(acc), 64'd4);
    chk("to_edge_err", 64'(rsp_err), 64'd0);
    chk("to_edge_rdata", 64'(rsp_rdata), 64'hA7);
`endif

    repeat (2) @(negedge pClk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fail_now("global_watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
